order_manager: RTL and testbench
================================

# order_manager

Sequential game-logic stage directly upstream of `graphics`. It produces `time_left`, `point_total`, `orders` and `order_times` from a one-second prescaler, a round timer, and an order queue of up to four orders. Orders spawn periodically, count down, expire with a penalty, and are retired oldest-first on delivery with a reward.

## Interface
- `CLK_HZ`, default 65_000_000: clock cycles per game second.
- `GAME_SECONDS`, default 120: round length in seconds; range 1..255.
- `ORDER_LIFE`, default 20: seconds an order lives; range 1..31.
- `SPAWN_PERIOD`, default 8: seconds between order spawns; range ≥1.
- `MAX_ORDERS`, default 4: queue depth; fixed at 4.
- `DELIVER_POINTS`, default 20: reward per delivered order.
- `EXPIRE_PENALTY`, default 10: penalty per expired order.
- `PLAY_STATE`, default 1: the `game_state` encoding that means "round in progress".
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `game_state`  in  3  global game state.
- `deliver`  in  1  one-cycle pulse: a full bowl was served.
- `time_left`  out  8  seconds remaining in the round.
- `point_total`  out  10  score, saturating 0..1023.
- `orders`  out  4  active order count, 0..4.
- `order_times`  out  [3:0][4:0]  per-slot seconds remaining.
  - Slot 0 is the oldest order.
  - Slots with index ≥ `orders` read 0.
- `deliver_ok`  out  1  one-cycle pulse: a delivery was accepted.
- `order_expired`  out  1  one-cycle pulse: slot 0 expired.
- `game_over`  out  1  high while in DONE.

## Operation
- FSM states:
  - IDLE: all outputs 0. Moves to PLAY when `game_state == PLAY_STATE`.
  - PLAY: the round is running (rules below).
  - DONE: `game_over`=1. `point_total` holds its value; `orders`, `order_times` and `time_left` are 0.
- FSM transitions:
  - PLAY → DONE when `time_left` goes 1→0.
  - PLAY → IDLE (abort) when `game_state != PLAY_STATE`.
  - DONE → IDLE when `game_state != PLAY_STATE`.
- PLAY entry loads the following:
  - `time_left`=GAME_SECONDS, `point_total`=0.
  - `orders`=1 with slot 0 = ORDER_LIFE.
  - Prescaler = 0, spawn counter = SPAWN_PERIOD.
- Prescaler: counts 0..CLK_HZ-1. `sec_tick` is high for the one cycle where the count wraps.
- On each `sec_tick` in PLAY, steps are applied in this order within the same cycle:
  1. `time_left` -= 1.
  2. Every active slot's time decrements by 1.
  3. If slot 0 reaches 0, remove it: shift slots down, `orders` -= 1, `point_total` = max(0, pts − EXPIRE_PENALTY), pulse `order_expired`. Only slot 0 can expire, because orders are FIFO with equal life.
  4. Spawn counter -= 1. On reaching 0 it reloads SPAWN_PERIOD. If `orders` < 4, append ORDER_LIFE at slot index `orders` and increment `orders`; otherwise the spawn is dropped.
- Delivery:
  - A `deliver` pulse sets a pending flag. Further pulses while the flag is set are merged into it.
  - The flag is serviced on the first PLAY cycle with `sec_tick` low.
  - If `orders` > 0: remove slot 0 with a shift-down, `point_total` = min(1023, pts + DELIVER_POINTS), pulse `deliver_ok`.
  - If `orders` == 0: clear the flag, no pulse, no score change.
  - The pending flag clears on leaving PLAY.
- Arithmetic: score saturates at both ends. Slot times never underflow, because a slot at 0 is removed in the same cycle.

## Timing
- Asynchronous reset (`reset`=0) forces IDLE, clears all outputs, the prescaler and the pending flag. It takes effect immediately, including mid-round.
- All outputs are registered.
- PLAY entry: `game_state` becomes PLAY_STATE at cycle N → loaded values are visible at N+1.
- Delivery latency:
  - `deliver` at cycle N with no tick at N or N+1 → update and `deliver_ok` visible at N+2 (flag set at N+1, serviced at N+1).
  - If a tick falls on the service cycle, service slips one cycle.
- First `sec_tick` occurs CLK_HZ cycles after PLAY entry.
- Abort is visible the cycle after `game_state` leaves PLAY_STATE.

## Test plan
Unless stated otherwise, parameters are CLK_HZ=10, GAME_SECONDS=5, ORDER_LIFE=3, SPAWN_PERIOD=2.
- Reset mid-round: pulse `reset` low during PLAY → all outputs 0 immediately. After release with `game_state`≠PLAY_STATE, the block stays in IDLE.
- Start: `game_state`=1 → `orders`=1, `order_times[0]`=3, `time_left`=5, `point_total`=0.
- Tick sequence, no deliveries:
  - Tick 2 → `orders`=2, times {1,3}.
  - Tick 3 → `order_expired` pulse, `orders`=1, slot 0=2, `point_total`=0 (saturated).
  - Tick 5 → `game_over`=1, `time_left`=0, `orders`=0.
- Deliver 3 cycles after start → `orders`=0, `point_total`=20, one `deliver_ok` pulse. A second `deliver` with the queue empty → no pulse, score still 20.
- Queue full: SPAWN_PERIOD=1, ORDER_LIFE=31 → `orders` saturates at 4 and further spawns are dropped. Then 60 deliveries → `point_total` saturates at 1023.
- Simultaneous events:
  - `deliver` asserted on a `sec_tick` cycle → delivery is applied after that tick's expiry and spawn, and `deliver_ok` arrives one cycle later.
  - Dropping `game_state` to 0 → IDLE the next cycle with all outputs 0.

Source files
------------

// File: rtl/order_manager_if.sv
// Status bus between the round/order game logic and its neighbours.
// deliver is a one-cycle request pulse with no back-pressure; deliver_ok is the one-cycle acceptance pulse.
interface order_manager_if;
    logic [2:0]      game_state;
    logic            deliver;
    logic [7:0]      time_left;
    logic [9:0]      point_total;
    logic [3:0]      orders;
    logic [3:0][4:0] order_times;
    logic            deliver_ok;
    logic            order_expired;
    logic            game_over;
    logic [1:0]      dbg_state;

    modport master (
        output game_state, deliver,
        input  time_left, point_total, orders, order_times,
        input  deliver_ok, order_expired, game_over, dbg_state
    );

    modport slave (
        input  game_state, deliver,
        output time_left, point_total, orders, order_times,
        output deliver_ok, order_expired, game_over, dbg_state
    );
endinterface

// File: rtl/order_manager.sv
// Round timer, score keeper and four-deep FIFO of timed orders feeding the graphics stage.
// Every output is a register; dbg_state mirrors the FSM state register.
module order_manager #(
    parameter int unsigned CLK_HZ         = 65_000_000,
    parameter int unsigned GAME_SECONDS   = 120,
    parameter int unsigned ORDER_LIFE     = 20,
    parameter int unsigned SPAWN_PERIOD   = 8,
    parameter int unsigned MAX_ORDERS     = 4,
    parameter int unsigned DELIVER_POINTS = 20,
    parameter int unsigned EXPIRE_PENALTY = 10,
    parameter logic [2:0]  PLAY_STATE     = 3'd1
) (
    input  logic           clock,
    input  logic           reset,
    order_manager_if.slave bus
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = $clog2(SPAWN_PERIOD + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SPAWN_LOAD = SW'(SPAWN_PERIOD);
    localparam logic [SW-1:0] SPAWN_ONE  = SW'(1);
    localparam logic [7:0]    TIME_LOAD  = 8'(GAME_SECONDS);
    localparam logic [4:0]    LIFE_LOAD  = 5'(ORDER_LIFE);
    localparam logic [2:0]    DEPTH      = 3'(MAX_ORDERS);
    localparam logic [11:0]   REWARD     = 12'(DELIVER_POINTS);
    localparam logic [11:0]   PENALTY    = 12'(EXPIRE_PENALTY);
    localparam logic [11:0]   SCORE_MAX  = 12'd1023;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [SW-1:0]   spawn_q, spawn_d;
    logic [7:0]      time_q, time_d;
    logic [9:0]      pts_q, pts_d;
    logic [2:0]      count_q, count_d;
    logic [3:0][4:0] slots_q, slots_d;
    logic            pending_q, pending_d;
    logic            ok_q, ok_d;
    logic            exp_q, exp_d;
    logic            over_q, over_d;

    logic            start;
    logic            sec_tick;
    logic [3:0][4:0] t_slots;
    logic [2:0]      t_count;
    logic [9:0]      t_pts;
    logic            t_expired;
    logic [11:0]     pts_wide;
    logic [11:0]     pts_sum;

    assign start = (bus.game_state == PLAY_STATE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            spawn_q   <= '0;
            time_q    <= '0;
            pts_q     <= '0;
            count_q   <= '0;
            slots_q   <= '0;
            pending_q <= 1'b0;
            ok_q      <= 1'b0;
            exp_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            spawn_q   <= spawn_d;
            time_q    <= time_d;
            pts_q     <= pts_d;
            count_q   <= count_d;
            slots_q   <= slots_d;
            pending_q <= pending_d;
            ok_q      <= ok_d;
            exp_q     <= exp_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        spawn_d   = spawn_q;
        time_d    = time_q;
        pts_d     = pts_q;
        count_d   = count_q;
        slots_d   = slots_q;
        pending_d = 1'b0;
        ok_d      = 1'b0;
        exp_d     = 1'b0;
        over_d    = 1'b0;
        sec_tick  = 1'b0;
        t_slots   = slots_q;
        t_count   = count_q;
        t_pts     = pts_q;
        t_expired = 1'b0;
        pts_wide  = {2'b00, pts_q};
        pts_sum   = pts_wide + REWARD;

        case (state_q)
            S_IDLE: begin
                pre_d   = '0;
                spawn_d = '0;
                time_d  = '0;
                pts_d   = '0;
                count_d = '0;
                slots_d = '0;
                if (start) begin
                    state_d    = S_PLAY;
                    time_d     = TIME_LOAD;
                    count_d    = 3'd1;
                    slots_d[0] = LIFE_LOAD;
                    spawn_d    = SPAWN_LOAD;
                end
            end

            S_PLAY: begin
                if (!start) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    spawn_d = '0;
                    time_d  = '0;
                    pts_d   = '0;
                    count_d = '0;
                    slots_d = '0;
                end else begin
                    sec_tick  = (pre_q == PRE_LAST);
                    pre_d     = sec_tick ? '0 : pre_q + PW'(1);
                    pending_d = pending_q;
                    if (sec_tick) begin
                        for (int i = 0; i < 4; i++) begin
                            if (3'(i) < count_q) t_slots[i] = slots_q[i] - 5'd1;
                        end
                        // Orders share one lifetime and are FIFO, so only the head can run out.
                        if (count_q != 3'd0 && t_slots[0] == 5'd0) begin
                            t_slots   = {5'd0, t_slots[3:1]};
                            t_count   = count_q - 3'd1;
                            t_pts     = (pts_wide > PENALTY) ? pts_q - PENALTY[9:0] : 10'd0;
                            t_expired = 1'b1;
                        end
                        if (spawn_q == SPAWN_ONE) begin
                            spawn_d = SPAWN_LOAD;
                            if (t_count < DEPTH) begin
                                t_slots[t_count[1:0]] = LIFE_LOAD;
                                t_count               = t_count + 3'd1;
                            end
                        end else begin
                            spawn_d = spawn_q - SPAWN_ONE;
                        end
                        exp_d = t_expired;
                        pts_d = t_pts;
                        if (time_q == 8'd1) begin
                            state_d   = S_DONE;
                            time_d    = '0;
                            count_d   = '0;
                            slots_d   = '0;
                            over_d    = 1'b1;
                            pending_d = 1'b0;
                        end else begin
                            time_d  = time_q - 8'd1;
                            count_d = t_count;
                            slots_d = t_slots;
                            if (bus.deliver) pending_d = 1'b1;
                        end
                    end else if (pending_q) begin
                        // A pulse arriving on the service cycle is merged into the request being retired.
                        pending_d = 1'b0;
                        if (count_q != 3'd0) begin
                            slots_d = {5'd0, slots_q[3:1]};
                            count_d = count_q - 3'd1;
                            pts_d   = (pts_sum > SCORE_MAX) ? 10'd1023 : pts_sum[9:0];
                            ok_d    = 1'b1;
                        end
                    end else if (bus.deliver) begin
                        pending_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                pre_d   = '0;
                spawn_d = '0;
                time_d  = '0;
                count_d = '0;
                slots_d = '0;
                if (start) begin
                    over_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    pts_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
                spawn_d = '0;
                time_d  = '0;
                pts_d   = '0;
                count_d = '0;
                slots_d = '0;
            end
        endcase
    end

    assign bus.time_left     = time_q;
    assign bus.point_total   = pts_q;
    assign bus.orders        = {1'b0, count_q};
    assign bus.order_times   = slots_q;
    assign bus.deliver_ok    = ok_q;
    assign bus.order_expired = exp_q;
    assign bus.game_over     = over_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_order_manager.sv
// Bench for order_manager: two instances (short round, and a long round with a fast spawner)
// checked every cycle against an integer model of the game rules, plus directed spot checks.
module tb_order_manager;
    localparam int A_CLK = 10, A_GAME = 5,   A_LIFE = 3,  A_SPAWN = 2;
    localparam int B_CLK = 10, B_GAME = 200, B_LIFE = 31, B_SPAWN = 1;
    localparam int REWARD = 20, PENALTY = 10;
    localparam logic [2:0] PLAY = 3'd1;
    localparam int OW = 45;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_DONE = 2;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    order_manager_if bus_a ();
    order_manager_if bus_b ();

    logic [2:0] gs [2];
    logic       del [2];

    assign bus_a.game_state = gs[0];
    assign bus_a.deliver    = del[0];
    assign bus_b.game_state = gs[1];
    assign bus_b.deliver    = del[1];

    order_manager #(
        .CLK_HZ(A_CLK), .GAME_SECONDS(A_GAME), .ORDER_LIFE(A_LIFE), .SPAWN_PERIOD(A_SPAWN)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a)
    );

    order_manager #(
        .CLK_HZ(B_CLK), .GAME_SECONDS(B_GAME), .ORDER_LIFE(B_LIFE), .SPAWN_PERIOD(B_SPAWN)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (bus_b)
    );

    int p_clk   [2] = '{A_CLK, B_CLK};
    int p_game  [2] = '{A_GAME, B_GAME};
    int p_life  [2] = '{A_LIFE, B_LIFE};
    int p_spawn [2] = '{A_SPAWN, B_SPAWN};

    // reference model: round state as plain integers, orders as an oldest-first array
    int m_st [2], m_tl [2], m_pts [2], m_n [2], m_pre [2], m_spawn [2];
    int m_slot [2][4];
    bit m_pend [2], m_ok [2], m_ex [2];

    logic [OW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic model_clear(input int k);
        m_st[k] = ST_IDLE; m_tl[k] = 0; m_pts[k] = 0; m_n[k] = 0;
        m_pre[k] = 0; m_spawn[k] = 0; m_pend[k] = 0; m_ok[k] = 0; m_ex[k] = 0;
        for (int i = 0; i < 4; i++) m_slot[k][i] = 0;
    endtask

    task automatic model_pop(input int k);
        for (int i = 0; i < 3; i++) m_slot[k][i] = m_slot[k][i + 1];
        m_slot[k][3] = 0;
        m_n[k] = m_n[k] - 1;
    endtask

    task automatic model_step(input int k);
        bit tick;
        m_ok[k] = 0;
        m_ex[k] = 0;
        if (m_st[k] == ST_IDLE) begin
            if (gs[k] == PLAY) begin
                model_clear(k);
                m_st[k] = ST_PLAY; m_tl[k] = p_game[k]; m_n[k] = 1;
                m_slot[k][0] = p_life[k]; m_spawn[k] = p_spawn[k];
            end
        end else if (m_st[k] == ST_DONE) begin
            if (gs[k] != PLAY) model_clear(k);
        end else if (gs[k] != PLAY) begin
            model_clear(k);
        end else begin
            tick = (m_pre[k] == p_clk[k] - 1);
            m_pre[k] = tick ? 0 : m_pre[k] + 1;
            if (tick) begin
                m_tl[k] = m_tl[k] - 1;
                for (int i = 0; i < m_n[k]; i++) m_slot[k][i] = m_slot[k][i] - 1;
                if (m_n[k] > 0 && m_slot[k][0] == 0) begin
                    model_pop(k);
                    m_pts[k] = (m_pts[k] > PENALTY) ? m_pts[k] - PENALTY : 0;
                    m_ex[k] = 1;
                end
                m_spawn[k] = m_spawn[k] - 1;
                if (m_spawn[k] == 0) begin
                    m_spawn[k] = p_spawn[k];
                    if (m_n[k] < 4) begin
                        m_slot[k][m_n[k]] = p_life[k];
                        m_n[k] = m_n[k] + 1;
                    end
                end
                if (m_tl[k] == 0) begin
                    m_st[k] = ST_DONE; m_n[k] = 0; m_pend[k] = 0;
                    for (int i = 0; i < 4; i++) m_slot[k][i] = 0;
                end else if (del[k]) begin
                    m_pend[k] = 1;
                end
            end else if (m_pend[k]) begin
                m_pend[k] = 0;
                if (m_n[k] > 0) begin
                    model_pop(k);
                    m_pts[k] = (m_pts[k] + REWARD > 1023) ? 1023 : m_pts[k] + REWARD;
                    m_ok[k] = 1;
                end
            end else if (del[k]) begin
                m_pend[k] = 1;
            end
        end
    endtask

    function automatic logic [OW-1:0] model_vec(input int k);
        logic [19:0] t;
        t = '0;
        for (int i = 0; i < 4; i++) t[i * 5 +: 5] = 5'(m_slot[k][i]);
        return {8'(m_tl[k]), 10'(m_pts[k]), 4'(m_n[k]), t, m_ok[k], m_ex[k], (m_st[k] == ST_DONE)};
    endfunction

    function automatic logic [OW-1:0] dut_vec(input int k);
        if (k == 0)
            return {bus_a.time_left, bus_a.point_total, bus_a.orders, bus_a.order_times,
                    bus_a.deliver_ok, bus_a.order_expired, bus_a.game_over};
        return {bus_b.time_left, bus_b.point_total, bus_b.orders, bus_b.order_times,
                bus_b.deliver_ok, bus_b.order_expired, bus_b.game_over};
    endfunction

    // scoreboard
    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, k, got, want);
        end
    endtask

    task automatic check_dut(input int k);
        logic [OW-1:0] got, want;
        exp_q.push_back(model_vec(k));
        got  = dut_vec(k);
        want = exp_q.pop_front();
        chk("time_left",     k, 32'(got[44:37]), 32'(want[44:37]));
        chk("point_total",   k, 32'(got[36:27]), 32'(want[36:27]));
        chk("orders",        k, 32'(got[26:23]), 32'(want[26:23]));
        chk("order_times",   k, 32'(got[22:3]),  32'(want[22:3]));
        chk("deliver_ok",    k, 32'(got[2]),     32'(want[2]));
        chk("order_expired", k, 32'(got[1]),     32'(want[1]));
        chk("game_over",     k, 32'(got[0]),     32'(want[0]));
    endtask

    // drivers
    task automatic step_cycle();
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (reset) model_step(k);
            else model_clear(k);
        end
        #1;
        for (int k = 0; k < 2; k++) check_dut(k);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic pulse_deliver(input int k);
        del[k] = 1'b1;
        step_cycle();
        del[k] = 1'b0;
    endtask

    initial begin
        int r;
        gs[0] = 3'd0; gs[1] = 3'd0; del[0] = 1'b0; del[1] = 1'b0;
        model_clear(0);
        model_clear(1);

        run(3);
        reset = 1'b1;
        run(2);
        chk("idle_orders", 0, 32'(bus_a.orders), 32'd0);

        // start and the no-delivery tick sequence
        gs[0] = PLAY;
        run(1);
        chk("start_orders", 0, 32'(bus_a.orders), 32'd1);
        chk("start_slot0",  0, 32'(bus_a.order_times[0]), 32'd3);
        chk("start_time",   0, 32'(bus_a.time_left), 32'd5);
        chk("start_points", 0, 32'(bus_a.point_total), 32'd0);
        run(20);
        chk("tick2_orders", 0, 32'(bus_a.orders), 32'd2);
        chk("tick2_slot0",  0, 32'(bus_a.order_times[0]), 32'd1);
        chk("tick2_slot1",  0, 32'(bus_a.order_times[1]), 32'd3);
        run(10);
        chk("tick3_expired", 0, 32'(bus_a.order_expired), 32'd1);
        chk("tick3_orders",  0, 32'(bus_a.orders), 32'd1);
        chk("tick3_slot0",   0, 32'(bus_a.order_times[0]), 32'd2);
        chk("tick3_points",  0, 32'(bus_a.point_total), 32'd0);
        run(20);
        chk("tick5_over",   0, 32'(bus_a.game_over), 32'd1);
        chk("tick5_time",   0, 32'(bus_a.time_left), 32'd0);
        chk("tick5_orders", 0, 32'(bus_a.orders), 32'd0);
        run(3);
        chk("done_hold", 0, 32'(bus_a.game_over), 32'd1);
        gs[0] = 3'd0;
        run(1);
        chk("done_exit", 0, 32'(bus_a.game_over), 32'd0);

        // delivery three cycles after start, then one into an empty queue
        gs[0] = PLAY;
        run(3);
        pulse_deliver(0);
        run(1);
        chk("deliver_ok",     0, 32'(bus_a.deliver_ok), 32'd1);
        chk("deliver_orders", 0, 32'(bus_a.orders), 32'd0);
        chk("deliver_points", 0, 32'(bus_a.point_total), 32'd20);
        run(1);
        pulse_deliver(0);
        run(2);
        chk("empty_points", 0, 32'(bus_a.point_total), 32'd20);
        chk("empty_ok",     0, 32'(bus_a.deliver_ok), 32'd0);
        gs[0] = 3'd0;
        run(1);
        chk("abort_time",   0, 32'(bus_a.time_left), 32'd0);
        chk("abort_points", 0, 32'(bus_a.point_total), 32'd0);

        // delivery request on the cycle of the first tick
        gs[0] = PLAY;
        run(10);
        pulse_deliver(0);
        chk("tick_del_time", 0, 32'(bus_a.time_left), 32'd4);
        chk("tick_del_ok0",  0, 32'(bus_a.deliver_ok), 32'd0);
        run(1);
        chk("tick_del_ok1",   0, 32'(bus_a.deliver_ok), 32'd1);
        chk("tick_del_orders", 0, 32'(bus_a.orders), 32'd0);

        // randomized deliveries and game_state changes
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) gs[0] = 3'd0;
            else if (r == 1) gs[0] = 3'($urandom_range(2, 7));
            else if (r <= 4) gs[0] = PLAY;
            run(int'($urandom_range(2, 12)));
            pulse_deliver(0);
        end

        // asynchronous reset in the middle of a round
        gs[0] = 3'd0;
        run(1);
        gs[0] = PLAY;
        run(15);
        #2 reset = 1'b0;
        #1;
        model_clear(0);
        model_clear(1);
        check_dut(0);
        chk("rst_time",   0, 32'(bus_a.time_left), 32'd0);
        chk("rst_orders", 0, 32'(bus_a.orders), 32'd0);
        chk("rst_slot0",  0, 32'(bus_a.order_times[0]), 32'd0);
        gs[0] = 3'd0;
        run(2);
        reset = 1'b1;
        run(3);
        chk("rst_stay_idle", 0, 32'(bus_a.time_left), 32'd0);

        // full queue and score saturation on the second instance
        gs[1] = PLAY;
        run(1);
        chk("b_start_slot0", 1, 32'(bus_b.order_times[0]), 32'd31);
        run(40);
        chk("b_full_orders", 1, 32'(bus_b.orders), 32'd4);
        run(20);
        chk("b_drop_orders", 1, 32'(bus_b.orders), 32'd4);
        for (int i = 0; i < 60; i++) begin
            pulse_deliver(1);
            run(int'($urandom_range(9, 12)));
        end
        chk("b_sat_points", 1, 32'(bus_b.point_total), 32'd1023);
        gs[1] = 3'd0;
        run(1);
        chk("b_abort_points", 1, 32'(bus_b.point_total), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
